// File: rtl/turf_pkg.sv
// Shared definitions for the territory game: player colours, screen geometry,
// count width and the scoring-stage state/entry types.
package turf_pkg;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] P1_COL = 3'b001;
  localparam logic [2:0] P2_COL = 3'b010;
  localparam logic [2:0] P3_COL = 3'b100;
  localparam logic [2:0] P4_COL = 3'b110;

  localparam int unsigned SCREEN_W     = 160;
  localparam int unsigned SCREEN_H     = 120;
  localparam int unsigned TOTAL_PIXELS = SCREEN_W * SCREEN_H;
  localparam int unsigned CNT_W        = 15;
  localparam int unsigned NUM_PLAYERS  = 4;
  localparam int unsigned SORT_STEPS   = 6;

  typedef logic [CNT_W-1:0] count_t;

  typedef struct packed {
    count_t     count;
    logic [2:0] colour;
  } rank_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_SORT,
    S_DONE
  } tally_state_t;

  function automatic logic [2:0] player_colour(input logic [1:0] idx);
    case (idx)
      2'd0:    player_colour = P1_COL;
      2'd1:    player_colour = P2_COL;
      2'd2:    player_colour = P3_COL;
      default: player_colour = P4_COL;
    endcase
  endfunction

  // Left index of the pair compared at each bubble-sort step.
  function automatic logic [1:0] pair_lo(input logic [2:0] step_idx);
    case (step_idx)
      3'd1:    pair_lo = 2'd1;
      3'd2:    pair_lo = 2'd2;
      3'd4:    pair_lo = 2'd1;
      default: pair_lo = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rank_sorter.sv
// Four-entry {count, colour} ranker: one compare-and-swap per step over a
// fixed six-step bubble schedule, descending by count, ties kept in order.
module rank_sorter
  import turf_pkg::*;
(
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         load,
  input  logic [NUM_PLAYERS*CNT_W-1:0] load_counts,
  input  logic                         step,
  output logic                         sorted,
  output logic [11:0]                  colours
);

  rank_entry_t ent [NUM_PLAYERS];
  logic [2:0]  step_cnt;
  logic [1:0]  lo;
  logic [1:0]  hi;

  assign lo = pair_lo(step_cnt);
  assign hi = lo + 2'd1;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        ent[i] <= '{count: '0, colour: player_colour(2'(i))};
      end
      step_cnt <= '0;
      sorted   <= 1'b0;
    end else if (load) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        ent[i] <= '{count: load_counts[i*CNT_W +: CNT_W], colour: player_colour(2'(i))};
      end
      step_cnt <= '0;
      sorted   <= 1'b0;
    end else if (step && step_cnt != 3'(SORT_STEPS)) begin
      // Strictly-greater swap keeps equal counts in player order.
      if (ent[hi].count > ent[lo].count) begin
        ent[lo] <= ent[hi];
        ent[hi] <= ent[lo];
      end
      step_cnt <= step_cnt + 3'd1;
      sorted   <= (step_cnt == 3'(SORT_STEPS - 1));
    end
  end

  assign colours = {ent[0].colour, ent[1].colour, ent[2].colour, ent[3].colour};

endmodule

// File: rtl/score_tally.sv
// End-of-game scoring: scans the territory RAM, counts pixels per player and
// ranks the players for the podium renderer.
module score_tally
  import turf_pkg::*;
#(
  parameter int unsigned SCREEN_W = turf_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = turf_pkg::SCREEN_H
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  output logic [14:0] ram_address,
  input  logic [2:0]  ram_q,
  output logic [14:0] p1_count,
  output logic [14:0] p2_count,
  output logic [14:0] p3_count,
  output logic [14:0] p4_count,
  output logic [11:0] ordered_colours,
  output logic        done_ordering,
  output logic        busy
);

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  tally_state_t state;
  logic [7:0]   x, x_nxt;
  logic [6:0]   y, y_nxt;
  logic         scan_valid;
  count_t       cnt     [NUM_PLAYERS];
  count_t       cnt_nxt [NUM_PLAYERS];
  logic         start_ok, scan_last, sort_load, sort_step, sorted;
  logic [NUM_PLAYERS*CNT_W-1:0] load_counts;
  logic [11:0]  sorted_colours;

  always_comb begin
    start_ok  = start && (state == S_IDLE || state == S_DONE);
    scan_last = (state == S_SCAN) && (x == X_LAST) && (y == Y_LAST);
    x_nxt = x;
    y_nxt = y + 7'd1;
    if (y == Y_LAST) begin
      y_nxt = '0;
      x_nxt = x + 8'd1;
    end
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) cnt_nxt[i] = cnt[i];
    if (state == S_SCAN && scan_valid) begin
      case (ram_q)
        P1_COL:  cnt_nxt[0] = cnt[0] + 15'd1;
        P2_COL:  cnt_nxt[1] = cnt[1] + 15'd1;
        P3_COL:  cnt_nxt[2] = cnt[2] + 15'd1;
        P4_COL:  cnt_nxt[3] = cnt[3] + 15'd1;
        default: ;
      endcase
    end
    // The sorter is loaded with zeros on start, then with the final counts
    // (including the last pixel, counted on the same edge) as SCAN ends.
    sort_load   = start_ok || scan_last;
    load_counts = '0;
    if (scan_last) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) load_counts[i*CNT_W +: CNT_W] = cnt_nxt[i];
    end
    sort_step = (state == S_SORT) && !sorted;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      x               <= '0;
      y               <= '0;
      scan_valid      <= 1'b0;
      ram_address     <= '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) cnt[i] <= '0;
      ordered_colours <= {P1_COL, P2_COL, P3_COL, P4_COL};
      done_ordering   <= 1'b0;
      busy            <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_SCAN;
            x             <= '0;
            y             <= '0;
            ram_address   <= '0;
            scan_valid    <= 1'b1;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) cnt[i] <= '0;
            done_ordering <= 1'b0;
            busy          <= 1'b1;
          end
        end
        S_SCAN: begin
          for (int unsigned i = 0; i < NUM_PLAYERS; i++) cnt[i] <= cnt_nxt[i];
          if (scan_last) begin
            state      <= S_SORT;
            scan_valid <= 1'b0;
          end else begin
            x           <= x_nxt;
            y           <= y_nxt;
            ram_address <= {x_nxt, y_nxt};
          end
        end
        S_SORT: begin
          if (sorted) begin
            state           <= S_DONE;
            ordered_colours <= sorted_colours;
            done_ordering   <= 1'b1;
            busy            <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign p1_count = cnt[0];
  assign p2_count = cnt[1];
  assign p3_count = cnt[2];
  assign p4_count = cnt[3];

  rank_sorter u_rank_sorter (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .load        (sort_load),
    .load_counts (load_counts),
    .step        (sort_step),
    .sorted      (sorted),
    .colours     (sorted_colours)
  );

endmodule

// File: tb/tb_score_tally.sv
// Scoreboard bench for score_tally: a behavioural RAM, a ranking model,
// and independent monitors for results and the address sequence.
module tb_score_tally;
  import turf_pkg::*;

  localparam int LATENCY = 19207;
  localparam int NPIX    = 19200;
  localparam logic [11:0] RESET_ORDER = 12'b001_010_100_110;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic        start    = 1'b0;
  logic [14:0] ram_address;
  logic [2:0]  ram_q;
  logic [14:0] p1_count, p2_count, p3_count, p4_count;
  logic [11:0] ordered_colours;
  logic        done_ordering, busy;

  logic [2:0] mem [0:32767];
  assign ram_q = mem[ram_address];

  score_tally #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .start           (start),
    .ram_address     (ram_address),
    .ram_q           (ram_q),
    .p1_count        (p1_count),
    .p2_count        (p2_count),
    .p3_count        (p3_count),
    .p4_count        (p4_count),
    .ordered_colours (ordered_colours),
    .done_ordering   (done_ordering),
    .busy            (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge CLOCK_50) cyc = cyc + 1;

  typedef struct packed {
    logic [3:0][14:0] cnt;
    logic [11:0]      ord;
    int               start_cyc;
  } exp_t;

  exp_t sb [$];
  bit   aborted = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: count by colour, then rank each player by how many others beat it.
  function automatic exp_t model(input int sc);
    int         c [4];
    logic [2:0] col [4];
    logic [2:0] v;
    int         r;
    exp_t       e;
    col = '{P1_COL, P2_COL, P3_COL, P4_COL};
    c   = '{0, 0, 0, 0};
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) begin
        v = mem[{8'(x), 7'(y)}];
        for (int p = 0; p < 4; p++) if (v == col[p]) c[p]++;
      end
    e.ord = '0;
    for (int i = 0; i < 4; i++) begin
      r = 0;
      for (int j = 0; j < 4; j++)
        if (c[j] > c[i] || (c[j] == c[i] && j < i)) r++;
      e.ord[11-3*r -: 3] = col[i];
      e.cnt[i] = 15'(c[i]);
    end
    e.start_cyc = sc;
    return e;
  endfunction

  // Result monitor: pops one expectation per rising done_ordering.
  exp_t mon_e;
  logic prev_done = 1'b0;
  always @(negedge CLOCK_50) begin
    if (done_ordering && !prev_done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("p1_count", p1_count, mon_e.cnt[0]);
        chk("p2_count", p2_count, mon_e.cnt[1]);
        chk("p3_count", p3_count, mon_e.cnt[2]);
        chk("p4_count", p4_count, mon_e.cnt[3]);
        chk("ordered_colours", ordered_colours, mon_e.ord);
        chk("latency", cyc - mon_e.start_cyc, LATENCY);
      end
    end
    prev_done = done_ordering;
  end

  // Address monitor: the k-th busy cycle must present {k/120, k%120}.
  int          addr_k    = 0;
  int          addr_errs = 0;
  logic        prev_busy = 1'b0;
  logic [14:0] exp_a;
  always @(negedge CLOCK_50) begin
    if (busy) begin
      if (!prev_busy) begin
        addr_k    = 0;
        addr_errs = 0;
      end
      if (addr_k < NPIX) begin
        exp_a = {8'(addr_k / 120), 7'(addr_k % 120)};
        if (addr_k == 0 || addr_k == 1 || addr_k == 119 || addr_k == 120 || addr_k == NPIX - 1)
          chk($sformatf("addr_%0d", addr_k), ram_address, exp_a);
        else if (ram_address !== exp_a) begin
          if (addr_errs == 0) chk($sformatf("addr_%0d", addr_k), ram_address, exp_a);
          addr_errs++;
        end
      end
      addr_k++;
    end else if (prev_busy) begin
      chk("addr_sequence_errors", addr_errs, 0);
      if (!aborted) chk("busy_cycles", addr_k, LATENCY);
      aborted = 1'b0;
    end
    prev_busy = busy;
  end

  // Unused rows (y >= 120) hold a player colour so stray reads would be counted.
  task automatic fill_const(input logic [2:0] v);
    for (int a = 0; a < 32768; a++) mem[a] = (a % 128 >= 120) ? P1_COL : v;
  endtask

  task automatic fill_stripes();
    int x;
    for (int a = 0; a < 32768; a++) begin
      x = a / 128;
      if (a % 128 >= 120) mem[a] = P1_COL;
      else if (x < 40)    mem[a] = P1_COL;
      else if (x < 80)    mem[a] = P2_COL;
      else if (x < 120)   mem[a] = P3_COL;
      else                mem[a] = P4_COL;
    end
    for (int y = 0; y < 100; y++) mem[{8'd0, 7'(y)}] = P4_COL;
  endtask

  task automatic fill_single();
    int rx, ry;
    fill_const(3'b111);
    rx = $urandom_range(0, 159);
    ry = $urandom_range(0, 119);
    mem[{8'(rx), 7'(ry)}] = P3_COL;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 32768; a++)
      mem[a] = (a % 128 >= 120) ? P2_COL : 3'($urandom_range(0, 7));
  endtask

  // Called just after a negedge; start is sampled at the next posedge.
  task automatic pulse_start(input bit expect_run);
    start = 1'b1;
    if (expect_run) sb.push_back(model(cyc + 1));
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < LATENCY + 100 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (done_ordering) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ram_address"}, ram_address, 0);
    chk({tag, "_p1"}, p1_count, 0);
    chk({tag, "_p2"}, p2_count, 0);
    chk({tag, "_p3"}, p3_count, 0);
    chk({tag, "_p4"}, p4_count, 0);
    chk({tag, "_order"}, ordered_colours, RESET_ORDER);
    chk({tag, "_done"}, done_ordering, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    fill_const(BLACK);
    repeat (3) @(negedge CLOCK_50);
    check_reset_values("rst");
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // All-black board, with start pulses during SCAN and during SORT.
    pulse_start(1'b1);
    repeat (100) @(negedge CLOCK_50);
    pulse_start(1'b0);
    repeat (19101) @(negedge CLOCK_50);
    chk("sort_busy", busy, 1);
    pulse_start(1'b0);
    wait_done();
    repeat (10) @(negedge CLOCK_50);
    chk("done_held", done_ordering, 1);
    chk("idle_busy", busy, 0);

    // Striped board restarted straight from DONE.
    fill_stripes();
    pulse_start(1'b1);
    chk("done_drop", done_ordering, 0);
    chk("restart_busy", busy, 1);
    wait_done();
    chk("stripes_p1", p1_count, 4700);
    chk("stripes_p4", p4_count, 4900);
    chk("stripes_order", ordered_colours, 12'b110_010_100_001);

    // Single pixel: abort mid-scan with reset, then a fresh tally.
    fill_single();
    pulse_start(1'b1);
    repeat (5000) @(negedge CLOCK_50);
    #2;
    aborted = 1'b1;
    resetn  = 1'b0;
    #1;
    check_reset_values("abort");
    sb.delete();
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    chk("no_auto_restart", busy, 0);
    pulse_start(1'b1);
    wait_done();
    chk("single_p3", p3_count, 1);
    chk("single_order", ordered_colours, 12'b100_001_010_110);

    // Random board.
    fill_random();
    pulse_start(1'b1);
    wait_done();

    repeat (3) @(negedge CLOCK_50);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
